// File: rtl/addr_gen.sv
// Kyber address generator: schedule counter -> coefficient RAM read/write word addresses and twiddle-ROM index.
// Optional ADDR_GEN_WEN_EN adds a registered w_en that qualifies w_addr.
module addr_gen #(
  parameter int unsigned WR_DLY = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic [7:0] clk_counter,
  output logic [6:0] coef_addr,
  output logic [4:0] r_addr,
  output logic [4:0] w_addr
`ifdef ADDR_GEN_WEN_EN
  ,
  output logic       w_en
`endif
);

  typedef enum logic [1:0] {
    MODE_NTT    = 2'd0,
    MODE_INVNTT = 2'd1,
    MODE_MULT   = 2'd2,
    MODE_ADDSUB = 2'd3
  } mode_t;

  mode_t      cur_mode;
  logic [2:0] layer;
  logic [4:0] slot;
  logic [2:0] eff;
  logic [2:0] pos;
  logic [4:0] half;
  logic [4:0] low_mask;
  logic [5:0] grp;
  logic [6:0] base;
  logic [4:0] r_nxt;
  logic [6:0] c_nxt;
  logic       slot_valid;

  logic [4:0] dl [WR_DLY];

  always_comb begin
    cur_mode   = mode_t'(mode);
    layer      = clk_counter[7:5];
    slot       = clk_counter[4:0];
    slot_valid = (layer != 3'd7);
    eff        = (cur_mode == MODE_NTT) ? layer : 3'd6 - layer;
    pos        = 3'd4 - eff;
    half       = {1'b0, slot[4:1]};
    low_mask   = (5'd1 << pos) - 5'd1;
    base       = 7'd1 << eff;
    grp        = '0;
    r_nxt      = '0;
    c_nxt      = '0;

    case (cur_mode)
      MODE_MULT: begin
        r_nxt = slot;
        c_nxt = 7'd64 + {1'b0, slot, 1'b0};
      end
      MODE_ADDSUB: begin
        r_nxt = slot;
      end
      default: begin
        if (slot_valid) begin
          // Slot LSB selects low/high word of the pair; it lands at bit (4-E) of the word address.
          if (eff <= 3'd4) begin
            r_nxt = ((half >> pos) << (pos + 3'd1)) | ({4'b0, slot[0]} << pos) | (half & low_mask);
            grp   = {1'b0, half >> pos};
          end else begin
            r_nxt = slot;
            grp   = (eff == 3'd5) ? {1'b0, slot} : {slot, 1'b0};
          end
          // INVNTT: (2<<6) wraps to 0 in 7 bits, giving 127-g as required.
          if (cur_mode == MODE_NTT)
            c_nxt = base + {1'b0, grp};
          else
            c_nxt = (base << 1) - 7'd1 - {1'b0, grp};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr    <= '0;
      coef_addr <= '0;
      for (int unsigned k = 0; k < WR_DLY; k++)
        dl[k] <= '0;
    end else begin
      r_addr    <= r_nxt;
      coef_addr <= c_nxt;
      dl[0]     <= r_addr;
      for (int unsigned k = 1; k < WR_DLY; k++)
        dl[k] <= dl[k-1];
    end
  end

  always_comb w_addr = dl[WR_DLY-1];

`ifdef ADDR_GEN_WEN_EN
  logic vld_q;
  logic vdl [WR_DLY];

  // Validity tracks r_addr one stage behind clk_counter, then follows the address delay line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      for (int unsigned k = 0; k < WR_DLY; k++)
        vdl[k] <= 1'b0;
    end else begin
      vld_q  <= slot_valid;
      vdl[0] <= vld_q;
      for (int unsigned k = 1; k < WR_DLY; k++)
        vdl[k] <= vdl[k-1];
    end
  end

  always_comb w_en = vdl[WR_DLY-1];
`endif

endmodule

// File: tb/tb_addr_gen.sv
// Self-checking bench for addr_gen: directed spec vectors plus a full NTT sweep with a write-delay scoreboard.
module tb_addr_gen;

  localparam int WR_DLY = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic [7:0] clk_counter;
  logic [6:0] coef_addr;
  logic [4:0] r_addr;
  logic [4:0] w_addr;
`ifdef ADDR_GEN_WEN_EN
  logic       w_en;
`endif

  addr_gen #(.WR_DLY(WR_DLY)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .clk_counter (clk_counter),
    .coef_addr   (coef_addr),
    .r_addr      (r_addr),
    .w_addr      (w_addr)
`ifdef ADDR_GEN_WEN_EN
    ,
    .w_en        (w_en)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] r;
    logic [6:0] c;
    logic [4:0] w;
    logic       en;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  // Bench-side write pipeline: expected r_addr history and slot validity.
  logic [4:0] m_r;
  logic       m_v;
  logic [4:0] m_dl  [WR_DLY];
  logic       m_vdl [WR_DLY];

  // Reference decode written in terms of pair distance d = 16>>E.
  task automatic model(input logic [1:0] m, input logic [7:0] cc,
                       output logic [4:0] r, output logic [6:0] c);
    int L, i, E, d, j, g, cv;
    L = int'(cc) >> 5;
    i = int'(cc) & 31;
    r = '0;
    c = '0;
    if (m == 2'd2) begin
      r = 5'(i);
      c = 7'(64 + 2 * i);
    end else if (m == 2'd3) begin
      r = 5'(i);
    end else if (L != 7) begin
      E = (m == 2'd0) ? L : 6 - L;
      if (E <= 4) begin
        d = 16 >> E;
        j = i >> 1;
        r = 5'((j / d) * 2 * d + (j % d) + (i & 1) * d);
        g = j / d;
      end else begin
        r = 5'(i);
        g = (E == 5) ? i : 2 * i;
      end
      cv = (m == 2'd0) ? (1 << E) + g : (2 << E) - 1 - g;
      c  = 7'(cv);
    end
  endtask

  // Drive one cycle; push what the DUT must show after this edge.
  task automatic tick(input logic rn, input logic [1:0] m, input logic [7:0] cc,
                      input logic [4:0] er, input logic [6:0] ec);
    exp_t x;
    rst_n       = rn;
    mode        = m;
    clk_counter = cc;
    if (!rn) begin
      for (int k = 0; k < WR_DLY; k++) begin
        m_dl[k]  = '0;
        m_vdl[k] = 1'b0;
      end
      m_r  = '0;
      m_v  = 1'b0;
      x.r  = '0;
      x.c  = '0;
    end else begin
      for (int k = WR_DLY - 1; k >= 1; k--) begin
        m_dl[k]  = m_dl[k-1];
        m_vdl[k] = m_vdl[k-1];
      end
      m_dl[0]  = m_r;
      m_vdl[0] = m_v;
      m_r      = er;
      m_v      = (cc[7:5] != 3'd7);
      x.r      = er;
      x.c      = ec;
    end
    x.w  = m_dl[WR_DLY-1];
    x.en = m_vdl[WR_DLY-1];
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int n = 0; n < 2; n++) begin
      tick(1'b0, 2'd0, 8'd37, 5'd0, 7'd0);
      e = exp_q.pop_front();
      total++; if (r_addr !== e.r)    begin bad++; $display("FAIL reset r_addr got=%0d want=%0d", r_addr, e.r); end
      total++; if (coef_addr !== e.c) begin bad++; $display("FAIL reset coef_addr got=%0d want=%0d", coef_addr, e.c); end
      total++; if (w_addr !== e.w)    begin bad++; $display("FAIL reset w_addr got=%0d want=%0d", w_addr, e.w); end
`ifdef ADDR_GEN_WEN_EN
      total++; if (w_en !== e.en)     begin bad++; $display("FAIL reset w_en got=%0b want=%0b", w_en, e.en); end
`endif
    end
  endtask

  task automatic test_ntt_l0();
    logic [4:0] er [4] = '{5'd0, 5'd16, 5'd1, 5'd17};
    for (int n = 0; n < 4; n++) begin
      tick(1'b1, 2'd0, 8'(n), er[n], 7'd1);
      e = exp_q.pop_front();
      total++; if (r_addr !== e.r)    begin bad++; $display("FAIL ntt_l0 cc=%0d r_addr got=%0d want=%0d", n, r_addr, e.r); end
      total++; if (coef_addr !== e.c) begin bad++; $display("FAIL ntt_l0 cc=%0d coef_addr got=%0d want=%0d", n, coef_addr, e.c); end
    end
  endtask

  task automatic test_ntt_l1();
    logic [7:0] cc [5] = '{8'd32, 8'd33, 8'd34, 8'd35, 8'd48};
    logic [4:0] er [5] = '{5'd0, 5'd8, 5'd1, 5'd9, 5'd16};
    logic [6:0] ec [5] = '{7'd2, 7'd2, 7'd2, 7'd2, 7'd3};
    for (int n = 0; n < 5; n++) begin
      tick(1'b1, 2'd0, cc[n], er[n], ec[n]);
      e = exp_q.pop_front();
      total++; if (r_addr !== e.r)    begin bad++; $display("FAIL ntt_l1 cc=%0d r_addr got=%0d want=%0d", cc[n], r_addr, e.r); end
      total++; if (coef_addr !== e.c) begin bad++; $display("FAIL ntt_l1 cc=%0d coef_addr got=%0d want=%0d", cc[n], coef_addr, e.c); end
    end
  endtask

  task automatic test_invntt();
    logic [7:0] cc [3] = '{8'd0, 8'd5, 8'd192};
    logic [4:0] er [3] = '{5'd0, 5'd5, 5'd0};
    logic [6:0] ec [3] = '{7'd127, 7'd117, 7'd1};
    for (int n = 0; n < 3; n++) begin
      tick(1'b1, 2'd1, cc[n], er[n], ec[n]);
      e = exp_q.pop_front();
      total++; if (r_addr !== e.r)    begin bad++; $display("FAIL invntt cc=%0d r_addr got=%0d want=%0d", cc[n], r_addr, e.r); end
      total++; if (coef_addr !== e.c) begin bad++; $display("FAIL invntt cc=%0d coef_addr got=%0d want=%0d", cc[n], coef_addr, e.c); end
    end
  endtask

  task automatic test_mult_addsub();
    logic [1:0] md [2] = '{2'd2, 2'd3};
    logic [6:0] ec [2] = '{7'd84, 7'd0};
    for (int n = 0; n < 2; n++) begin
      tick(1'b1, md[n], 8'd10, 5'd10, ec[n]);
      e = exp_q.pop_front();
      total++; if (r_addr !== e.r)    begin bad++; $display("FAIL mode%0d r_addr got=%0d want=%0d", md[n], r_addr, e.r); end
      total++; if (coef_addr !== e.c) begin bad++; $display("FAIL mode%0d coef_addr got=%0d want=%0d", md[n], coef_addr, e.c); end
    end
  endtask

  // Full NTT sweep, then invalid L=7 slots so w_en (if present) drops after the pipeline drains.
  task automatic test_write_delay();
    logic [4:0] er;
    logic [6:0] ec;
    for (int n = 0; n < 232; n++) begin
      model(2'd0, 8'(n), er, ec);
      tick(1'b1, 2'd0, 8'(n), er, ec);
      e = exp_q.pop_front();
      total++; if (r_addr !== e.r)    begin bad++; $display("FAIL sweep cc=%0d r_addr got=%0d want=%0d", n, r_addr, e.r); end
      total++; if (coef_addr !== e.c) begin bad++; $display("FAIL sweep cc=%0d coef_addr got=%0d want=%0d", n, coef_addr, e.c); end
      total++; if (w_addr !== e.w)    begin bad++; $display("FAIL sweep cc=%0d w_addr got=%0d want=%0d", n, w_addr, e.w); end
`ifdef ADDR_GEN_WEN_EN
      total++; if (w_en !== e.en)     begin bad++; $display("FAIL sweep cc=%0d w_en got=%0b want=%0b", n, w_en, e.en); end
`endif
    end
  endtask

  // INVNTT traffic with a one-cycle reset in the middle.
  task automatic test_reset_mid();
    logic [4:0] er;
    logic [6:0] ec;
    for (int n = 60; n < 80; n++) begin
      model(2'd1, 8'(n), er, ec);
      tick((n != 68), 2'd1, 8'(n), er, ec);
      e = exp_q.pop_front();
      total++; if (r_addr !== e.r)    begin bad++; $display("FAIL rst_mid cc=%0d r_addr got=%0d want=%0d", n, r_addr, e.r); end
      total++; if (coef_addr !== e.c) begin bad++; $display("FAIL rst_mid cc=%0d coef_addr got=%0d want=%0d", n, coef_addr, e.c); end
      total++; if (w_addr !== e.w)    begin bad++; $display("FAIL rst_mid cc=%0d w_addr got=%0d want=%0d", n, w_addr, e.w); end
`ifdef ADDR_GEN_WEN_EN
      total++; if (w_en !== e.en)     begin bad++; $display("FAIL rst_mid cc=%0d w_en got=%0b want=%0b", n, w_en, e.en); end
`endif
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    mode        = 2'd0;
    clk_counter = 8'd0;
    test_reset();
    test_ntt_l0();
    test_ntt_l1();
    test_invntt();
    test_mult_addsub();
    test_write_delay();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
